axis_operand_joiner: RTL and testbench
======================================

Name: axis_operand_joiner

Overview:
- Tile-side ingress stage that sits directly downstream of an axis_mesh output port and upstream of a two-operand compute tile, such as the adder.
- Receives single-beat operand packets from two producer tiles, which arrive interleaved on one AXI-Stream slave and are distinguished by TID.
- Buffers each source in its own FIFO.
- Emits one joined beat {B,A} per matched pair, in arrival order per source, on an AXI-Stream master.

Parameters:
- TDATAW, 32, operand width.
- TDESTW, 4, destination field width.
- TIDW, 4, source-ID field width.
- SRC_A_ID, 0, TID value of operand-A producer.
- SRC_B_ID, 2, TID value of operand-B producer.
- FIFO_DEPTH, 4, entries per source FIFO; power of two, at least 2.
- OUT_TDEST, 3, TDEST driven on every joined beat.
- CNTW, 16, width of status counters.

Ports:
- CLK  in  1  single clock.
- RST  in  1  asynchronous reset, active-high.
- AXIS_S_TVALID  in  1  slave beat valid.
- AXIS_S_TREADY  out  1  slave ready.
- AXIS_S_TDATA  in  TDATAW  operand value.
- AXIS_S_TLAST  in  1  end of packet; must be 1 for a legal beat.
- AXIS_S_TID  in  TIDW  producer ID.
- AXIS_S_TDEST  in  TDESTW  ignored.
- AXIS_M_TVALID  out  1  joined beat valid.
- AXIS_M_TREADY  in  1  downstream ready.
- AXIS_M_TDATA  out  2*TDATAW  {B operand, A operand}; A occupies the low half.
- AXIS_M_TLAST  out  1  constant 1 while valid.
- AXIS_M_TDEST  out  TDESTW  OUT_TDEST.
- PAIR_CNT  out  CNTW  joined beats delivered (M handshakes).
- DROP_CNT  out  CNTW  beats discarded.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - Input register, both FIFOs and output register are emptied.
  - AXIS_S_TREADY=0 while RST is high; it is 1 on the first cycle after release.
  - AXIS_M_TVALID=0, AXIS_M_TDATA=0, PAIR_CNT=0, DROP_CNT=0.
  - RST asserted mid-operation discards all buffered operands; there is no partial-pair recovery.
- Input stage: one-entry register.
  - S handshake when TVALID and TREADY are both high.
  - AXIS_S_TREADY = !in_valid || in_drain, where in_drain means the registered beat leaves this cycle.
  - TREADY never depends combinationally on TDATA, TID or TDEST.
- Classification of the registered beat, one cycle after acceptance:
  - TID==SRC_A_ID with TLAST=1: write to FIFO_A.
  - TID==SRC_B_ID with TLAST=1: write to FIFO_B.
  - Any other TID, or TLAST=0: drop. in_drain=1 and DROP_CNT increments, saturating at all-ones.
  - A beat targeting a full FIFO stays in the input register (in_drain=0), which stalls the whole slave. No drop on full.
- FIFOs:
  - Circular buffers with pointers one bit wider than the address.
  - full = address bits equal and MSBs differ; empty = pointers equal.
  - Simultaneous write and pop on a full FIFO is not allowed, because the write is gated by full from the previous state.
  - Simultaneous write and pop on a non-full FIFO is legal; the count stays unchanged.
- Join / output register:
  - load = !FIFO_A.empty && !FIFO_B.empty && (!M_TVALID || M_TREADY).
  - On load, both FIFOs pop in the same cycle and M_TDATA <= {B_head, A_head}.
  - M_TVALID and M_TDATA hold stable until the handshake.
  - Back-to-back loads give one joined beat per cycle when M_TREADY stays high.
- Latency: if the partner operand is already queued and the output is free, a beat accepted on edge k writes its FIFO on edge k+1 and M_TVALID rises after edge k+2. Minimum input-to-output latency is 2 cycles.
- Ordering: strictly FIFO per source. The n-th A always joins the n-th B.
- Counters:
  - PAIR_CNT increments on each M handshake and wraps modulo 2^CNTW.
  - DROP_CNT saturates at all-ones.
- State machine: none beyond the valid bits. Control is the three-stage pipeline plus pointer logic.

Decomposition:
- Shared package noc_tile_pkg:
  - Tile ID constants (SRC_A_ID, SRC_B_ID, output-tile ID) for the 2x2 mesh.
  - typedef operand_t (logic [TDATAW-1:0]).
  - typedef joined_t (struct packed {operand_t b; operand_t a;}).
- One sub-module: joiner_fifo, a parameterized synchronous FIFO with width and depth parameters and wr_en, rd_en, full and empty outputs. It is instantiated twice.

Test Plan:
- Reset, then A(TID0)=0x11, B(TID2)=0x22, M_TREADY=1. Required: one beat with TDATA=0x00000022_00000011, TLAST=1, TDEST=3; PAIR_CNT=1.
- Send A=1,2,3,4 with no B, then B=10,20,30,40. Required: 4 beats {10,1},{20,2},{30,3},{40,4} in order; TREADY never drops, since depth 4 is sufficient.
- Hold M_TREADY=0 and send 6 A plus 6 B, interleaved. Required: TREADY deasserts once the FIFOs and output register are full, no beat is lost, no DROP_CNT change. On release, 6 correctly paired beats.
- Send beats with TID=5, then TID=0 with TLAST=0. Required: both accepted and discarded, DROP_CNT=2, no M beat, and FIFO_A still empty.
- Pulse RST after 3 A and 1 B have been accepted and while M_TVALID=1. Required: M_TVALID=0 and counters 0 during reset. Afterward, a fresh A=0x5 and B=0x6 produce {6,5}, with no stale operands.
- Continuous alternating A/B stream of 100 pairs with M_TREADY=1. Required: steady-state throughput of 1 joined beat per 2 input beats, PAIR_CNT=100, sums verified by the scoreboard.

Source files
------------

// File: rtl/noc_tile_pkg.sv
// Shared constants and operand types for the 2x2 mesh compute tiles.
// Tile IDs identify producers; joined_t packs an operand pair as {b, a}.
package noc_tile_pkg;

    localparam int OPERAND_W       = 32;
    localparam int TILE_ID_W       = 4;
    localparam int TILE_DEST_W     = 4;
    localparam int A_TILE_ID       = 0;
    localparam int B_TILE_ID       = 2;
    localparam int OUT_TILE_ID     = 3;
    localparam int JOIN_FIFO_DEPTH = 4;
    localparam int STAT_CNT_W      = 16;

    typedef logic [OPERAND_W-1:0] operand_t;

    typedef struct packed {
        operand_t b;
        operand_t a;
    } joined_t;

endpackage

// File: rtl/axis_operand_joiner_if.sv
// AXI-Stream bundle used on both sides of the operand joiner.
// The master drives the beat; the slave drives TREADY.
interface axis_operand_joiner_if
    import noc_tile_pkg::*;
#(
    parameter int DW    = OPERAND_W,
    parameter int IDW   = TILE_ID_W,
    parameter int DESTW = TILE_DEST_W
);
    logic             TVALID;
    logic             TREADY;
    logic [DW-1:0]    TDATA;
    logic             TLAST;
    logic [IDW-1:0]   TID;
    logic [DESTW-1:0] TDEST;

    modport master (
        output TVALID, TDATA, TLAST, TID, TDEST,
        input  TREADY
    );

    modport slave (
        input  TVALID, TDATA, TLAST, TID, TDEST,
        output TREADY
    );
endinterface

// File: rtl/axis_operand_joiner_fifo.sv
// Per-source operand FIFO: circular buffer with wrap-bit pointers.
// Read data is the current head, valid whenever empty is low.
module joiner_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0])
                && (wptr[AW] != rptr[AW]);
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define the contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/axis_operand_joiner.sv
// Joins A/B operand beats from one interleaved AXI-Stream into {B,A}.
// Pipeline: input register -> per-source FIFOs -> output register.
module axis_operand_joiner
    import noc_tile_pkg::*;
#(
    parameter int TDATAW     = OPERAND_W,
    parameter int TDESTW     = TILE_DEST_W,
    parameter int TIDW       = TILE_ID_W,
    parameter int SRC_A_ID   = A_TILE_ID,
    parameter int SRC_B_ID   = B_TILE_ID,
    parameter int FIFO_DEPTH = JOIN_FIFO_DEPTH,
    parameter int OUT_TDEST  = OUT_TILE_ID,
    parameter int CNTW       = STAT_CNT_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    axis_operand_joiner_if.slave  AXIS_S,
    axis_operand_joiner_if.master AXIS_M,
    output logic [CNTW-1:0]       PAIR_CNT,
    output logic [CNTW-1:0]       DROP_CNT
);
    logic              in_valid;
    logic              in_last;
    logic [TDATAW-1:0] in_data;
    logic [TIDW-1:0]   in_tid;

    logic is_a, is_b, is_drop;
    logic wr_a, wr_b, in_drain;
    logic s_hs, m_hs, load;

    logic              full_a, empty_a;
    logic              full_b, empty_b;
    logic [TDATAW-1:0] head_a, head_b;

    logic                m_valid;
    logic [2*TDATAW-1:0] m_data;

    assign s_hs = AXIS_S.TVALID && AXIS_S.TREADY;

    assign is_a = in_valid && in_last
               && (in_tid == TIDW'(SRC_A_ID));
    assign is_b = in_valid && in_last
               && (in_tid == TIDW'(SRC_B_ID));
    assign is_drop = in_valid && !is_a && !is_b;

    // A beat facing a full FIFO waits here and stalls the slave.
    assign wr_a     = is_a && !full_a;
    assign wr_b     = is_b && !full_b;
    assign in_drain = wr_a || wr_b || is_drop;

    assign AXIS_S.TREADY = !RST && (!in_valid || in_drain);

    assign m_hs = m_valid && AXIS_M.TREADY;
    assign load = !empty_a && !empty_b
               && (!m_valid || AXIS_M.TREADY);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_valid <= 1'b0;
            in_last  <= 1'b0;
            in_data  <= '0;
            in_tid   <= '0;
        end else if (s_hs) begin
            in_valid <= 1'b1;
            in_last  <= AXIS_S.TLAST;
            in_data  <= AXIS_S.TDATA;
            in_tid   <= AXIS_S.TID;
        end else if (in_drain) begin
            in_valid <= 1'b0;
        end
    end

    joiner_fifo #(
        .W     (TDATAW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_a (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (wr_a),
        .wr_data (in_data),
        .rd_en   (load),
        .rd_data (head_a),
        .full    (full_a),
        .empty   (empty_a)
    );

    joiner_fifo #(
        .W     (TDATAW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_b (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (wr_b),
        .wr_data (in_data),
        .rd_en   (load),
        .rd_data (head_b),
        .full    (full_b),
        .empty   (empty_b)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= {head_b, head_a};
        end else if (m_hs) begin
            m_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PAIR_CNT <= '0;
            DROP_CNT <= '0;
        end else begin
            if (m_hs)
                PAIR_CNT <= PAIR_CNT + 1'b1;
            if (is_drop && (DROP_CNT != '1))
                DROP_CNT <= DROP_CNT + 1'b1;
        end
    end

    assign AXIS_M.TVALID = m_valid;
    assign AXIS_M.TDATA  = m_data;
    assign AXIS_M.TLAST  = 1'b1;
    assign AXIS_M.TID    = '0;
    assign AXIS_M.TDEST  = TDESTW'(OUT_TDEST);
endmodule

// File: tb/tb_axis_operand_joiner.sv
// Scenario bench for axis_operand_joiner with a pairing scoreboard.
// Expected {B,A} beats are queued as legal operands are accepted.
module tb_axis_operand_joiner;
    import noc_tile_pkg::*;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic [3:0]  dst;
    } rx_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] PAIR_CNT;
    logic [15:0] DROP_CNT;

    axis_operand_joiner_if #(.DW(32), .IDW(4), .DESTW(4)) s_if();
    axis_operand_joiner_if #(.DW(64), .IDW(4), .DESTW(4)) m_if();

    axis_operand_joiner dut (
        .CLK      (CLK),
        .RST      (RST),
        .AXIS_S   (s_if),
        .AXIS_M   (m_if),
        .PAIR_CNT (PAIR_CNT),
        .DROP_CNT (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int       vectors = 0;
    int       miscompares = 0;
    int       cyc = 0;
    bit       saw_stall = 0;
    operand_t qa[$];
    operand_t qb[$];
    joined_t  exp_q[$];
    rx_t      rx_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!RST && m_if.TVALID && m_if.TREADY)
            rx_q.push_back(rx_t'{m_if.TDATA, m_if.TLAST, m_if.TDEST});
        if (!RST && s_if.TVALID && !s_if.TREADY)
            saw_stall = 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] id,
                        input logic last);
        int n;
        bit done;
        joined_t j;
        n = 0;
        done = 0;
        s_if.TVALID = 1'b1;
        s_if.TDATA  = d;
        s_if.TID    = id;
        s_if.TLAST  = last;
        s_if.TDEST  = 4'h0;
        while (!done) begin
            @(negedge CLK);
            if (s_if.TREADY) begin
                done = 1;
                if (last && id == 4'(A_TILE_ID)) qa.push_back(d);
                if (last && id == 4'(B_TILE_ID)) qb.push_back(d);
                while (qa.size() > 0 && qb.size() > 0) begin
                    j.a = qa.pop_front();
                    j.b = qb.pop_front();
                    exp_q.push_back(j);
                end
            end else if (++n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout data=%h tid=%0d", d, id);
                done = 1;
            end
            @(posedge CLK);
            #1;
        end
        s_if.TVALID = 1'b0;
    endtask

    task automatic collect(input int n);
        int k;
        k = 0;
        while (rx_q.size() < n && k < 500) begin
            step(1);
            k++;
        end
        if (rx_q.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL collect_timeout got %0d want %0d",
                     rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        s_if.TVALID = 1'b0;
        s_if.TDATA  = '0;
        s_if.TID    = '0;
        s_if.TLAST  = 1'b0;
        s_if.TDEST  = '0;
        m_if.TREADY = 1'b0;
        RST = 1'b1;
        step(3);
        vectors++;
        if (s_if.TREADY !== 1'b0 || m_if.TVALID !== 1'b0
            || m_if.TDATA !== 64'h0 || PAIR_CNT !== 16'h0
            || DROP_CNT !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state rdy=%b vld=%b data=%h pc=%0d dc=%0d want 0,0,0,0,0",
                     s_if.TREADY, m_if.TVALID, m_if.TDATA,
                     PAIR_CNT, DROP_CNT);
        end
        RST = 1'b0;
        #1;
        vectors++;
        if (s_if.TREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready got %b want 1", s_if.TREADY);
        end
    endtask

    task automatic test_single();
        rx_t r;
        m_if.TREADY = 1'b1;
        send(32'h11, 4'd0, 1'b1);
        send(32'h22, 4'd2, 1'b1);
        step(1);
        vectors++;
        if (m_if.TVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early_valid got %b want 0", m_if.TVALID);
        end
        step(1);
        vectors++;
        if (m_if.TVALID !== 1'b1
            || m_if.TDATA !== 64'h00000022_00000011) begin
            miscompares++;
            $display("FAIL single_latency vld=%b data=%h want 1 0000002200000011",
                     m_if.TVALID, m_if.TDATA);
        end
        collect(1);
        vectors++;
        if (rx_q.size() == 0 || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL single_beat missing rx=%0d exp=%0d",
                     rx_q.size(), exp_q.size());
        end else begin
            r = rx_q.pop_front();
            if (r.d !== 64'(exp_q.pop_front()) || r.l !== 1'b1
                || r.dst !== 4'd3) begin
                miscompares++;
                $display("FAIL single_beat data=%h last=%b dest=%0d want 0000002200000011 1 3",
                         r.d, r.l, r.dst);
            end
        end
        step(2);
        vectors++;
        if (PAIR_CNT !== 16'd1) begin
            miscompares++;
            $display("FAIL single_pair_cnt got %0d want 1", PAIR_CNT);
        end
    endtask

    task automatic test_a_then_b();
        rx_t r;
        joined_t e;
        saw_stall = 0;
        m_if.TREADY = 1'b1;
        for (int i = 1; i <= 4; i++) send(32'(i), 4'd0, 1'b1);
        for (int i = 1; i <= 4; i++) send(32'(10 * i), 4'd2, 1'b1);
        collect(4);
        vectors++;
        if (saw_stall) begin
            miscompares++;
            $display("FAIL a_then_b_stall got stall=1 want 0");
        end
        repeat (4) begin
            vectors++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL a_then_b_missing rx=%0d exp=%0d",
                         rx_q.size(), exp_q.size());
            end else begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                if (r.d !== 64'(e)) begin
                    miscompares++;
                    $display("FAIL a_then_b_data got %h want %h", r.d, e);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        rx_t r;
        joined_t e;
        logic [15:0] drop0;
        drop0 = DROP_CNT;
        saw_stall = 0;
        m_if.TREADY = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(32'h100 + 32'(i), 4'd0, 1'b1);
                    send(32'h200 + 32'(i), 4'd2, 1'b1);
                end
            end
            begin
                int k;
                k = 0;
                while (!saw_stall && k < 300) begin
                    step(1);
                    k++;
                end
                step(4);
                vectors++;
                if (m_if.TVALID !== 1'b1
                    || m_if.TDATA !== 64'h00000200_00000100) begin
                    miscompares++;
                    $display("FAIL bp_hold vld=%b data=%h want 1 0000020000000100",
                             m_if.TVALID, m_if.TDATA);
                end
                m_if.TREADY = 1'b1;
            end
        join
        vectors++;
        if (!saw_stall) begin
            miscompares++;
            $display("FAIL bp_stall got stall=0 want 1");
        end
        collect(6);
        repeat (6) begin
            vectors++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL bp_missing rx=%0d exp=%0d",
                         rx_q.size(), exp_q.size());
            end else begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                if (r.d !== 64'(e)) begin
                    miscompares++;
                    $display("FAIL bp_data got %h want %h", r.d, e);
                end
            end
        end
        vectors++;
        if (DROP_CNT !== drop0) begin
            miscompares++;
            $display("FAIL bp_drop_cnt got %0d want %0d", DROP_CNT, drop0);
        end
    endtask

    task automatic test_drop();
        rx_t r;
        m_if.TREADY = 1'b1;
        send(32'h55, 4'd5, 1'b1);
        send(32'h99, 4'd0, 1'b0);
        step(3);
        vectors++;
        if (DROP_CNT !== 16'd2) begin
            miscompares++;
            $display("FAIL drop_cnt got %0d want 2", DROP_CNT);
        end
        send(32'h66, 4'd2, 1'b1);
        step(4);
        vectors++;
        if (rx_q.size() != 0) begin
            miscompares++;
            $display("FAIL drop_no_beat got %0d beats want 0", rx_q.size());
        end
        send(32'h77, 4'd0, 1'b1);
        collect(1);
        vectors++;
        if (rx_q.size() == 0) begin
            miscompares++;
            $display("FAIL drop_pair missing want 0000006600000077");
        end else begin
            r = rx_q.pop_front();
            if (r.d !== 64'h00000066_00000077) begin
                miscompares++;
                $display("FAIL drop_pair got %h want 0000006600000077", r.d);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_mid_reset();
        rx_t r;
        m_if.TREADY = 1'b0;
        send(32'h1, 4'd0, 1'b1);
        send(32'h2, 4'd0, 1'b1);
        send(32'h3, 4'd0, 1'b1);
        send(32'h9, 4'd2, 1'b1);
        step(2);
        vectors++;
        if (m_if.TVALID !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rst_pre_valid got %b want 1", m_if.TVALID);
        end
        RST = 1'b1;
        #1;
        vectors++;
        if (m_if.TVALID !== 1'b0 || PAIR_CNT !== 16'd0
            || DROP_CNT !== 16'd0 || s_if.TREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst_state vld=%b pc=%0d dc=%0d rdy=%b want 0 0 0 0",
                     m_if.TVALID, PAIR_CNT, DROP_CNT, s_if.TREADY);
        end
        step(2);
        RST = 1'b0;
        qa.delete();
        qb.delete();
        exp_q.delete();
        rx_q.delete();
        m_if.TREADY = 1'b1;
        send(32'h5, 4'd0, 1'b1);
        send(32'h6, 4'd2, 1'b1);
        collect(1);
        vectors++;
        if (rx_q.size() == 0) begin
            miscompares++;
            $display("FAIL mid_rst_pair missing want 0000000600000005");
        end else begin
            r = rx_q.pop_front();
            if (r.d !== 64'h00000006_00000005) begin
                miscompares++;
                $display("FAIL mid_rst_pair got %h want 0000000600000005", r.d);
            end
        end
        exp_q.delete();
        step(1);
        vectors++;
        if (PAIR_CNT !== 16'd1) begin
            miscompares++;
            $display("FAIL mid_rst_pair_cnt got %0d want 1", PAIR_CNT);
        end
    endtask

    task automatic test_stream();
        rx_t r;
        joined_t e;
        int t0, bad;
        logic [15:0] base;
        base = PAIR_CNT;
        saw_stall = 0;
        bad = 0;
        m_if.TREADY = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 100; i++) begin
            send($urandom, 4'd0, 1'b1);
            send($urandom, 4'd2, 1'b1);
        end
        collect(100);
        vectors++;
        if (cyc - t0 < 200 || cyc - t0 > 210 || saw_stall) begin
            miscompares++;
            $display("FAIL stream_rate cycles=%0d stall=%b want 200..210 0",
                     cyc - t0, saw_stall);
        end
        repeat (100) begin
            vectors++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL stream_missing rx=%0d exp=%0d",
                         rx_q.size(), exp_q.size());
            end else begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                if (r.d !== 64'(e)) begin
                    miscompares++;
                    if (bad++ < 5)
                        $display("FAIL stream_data got %h want %h", r.d, e);
                end
            end
        end
        step(2);
        vectors++;
        if (PAIR_CNT !== base + 16'd100) begin
            miscompares++;
            $display("FAIL stream_pair_cnt got %0d want %0d",
                     PAIR_CNT, base + 16'd100);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_a_then_b();
        test_backpressure();
        test_drop();
        test_mid_reset();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
